data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised, byte-addressed data memory for the MIPS datapath MEM stage. It supports byte, halfword and word stores and loads (signed or unsigned) through a valid/ready request port and a registered response. An internal clear sequencer zeroes every entry after reset, so memory contents are deterministic without per-entry reset logic. Misaligned, illegal-size and out-of-range accesses are flagged and suppressed.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, minimum 4.
ADDR_W, 32, width of the byte address port.
IDX_W, $clog2(DEPTH), word index width; derived, not overridden.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  reset, synchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  block accepts a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  load zero-extends (lbu/lhu); ignored for stores and words.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data; byte/half taken from the low bits.
rsp_valid  out  1  one-cycle pulse, response for an accepted request.
rsp_rdata  out  32  load result, extended; 0 for stores and errors.
rsp_err  out  1  qualified by rsp_valid; access was suppressed.
busy  out  1  clear sequence in progress.

Behaviour:
- States: CLEAR, IDLE. Reset forces state=CLEAR, clr_idx=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. clr_idx holds at 0 while reset is high.
- CLEAR: each cycle write 0 to mem[clr_idx] and increment. In the cycle clr_idx==DEPTH-1, write and go to IDLE. req_ready becomes 1 after exactly DEPTH rising edges with reset low. busy = (state==CLEAR).
- Reset asserted mid-clear or mid-operation restarts CLEAR from index 0. Any in-flight response is dropped (rsp_valid=0).
- req_ready = (state==IDLE). A request is accepted on a rising edge with req_valid && req_ready. There is at most one request per cycle, with no backpressure on the response.
- Decode: idx = req_addr[IDX_W+1:2], lane = req_addr[1:0].
- Error when any of the following holds: size==11; half with lane[0]=1; word with lane!=00; req_addr[ADDR_W-1:IDX_W+2] nonzero.
- On error: no write, rsp_err=1, rsp_rdata=0.
- Store: byte enables are byte = 1<<lane, half = 0011<<lane, word = 1111. Lane data is replicated from the low bits. The write commits on the accept edge.
- Load: the selected byte or half is right-aligned, then sign-extended unless req_unsigned.
- Latency: the response is registered. rsp_valid is 1 exactly in the cycle after accept, otherwise 0. A store also yields a response (rdata=0, err per check).
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. There is no stale read.
- Responses hold rsp_rdata/rsp_err until the next response or reset. Only rsp_valid pulses.

Decomposition:
- Shared package mips_mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, and a byte-enable function.
- One natural sub-module, load_align_ext. It is combinational: lane, size and unsigned in, aligned and extended 32-bit data out. It is shared with a future instruction-side memory.

Test Plan:
- Reset with DEPTH=16, then release -> busy=1 and req_ready=0 for 16 cycles. After that, word loads at 0x00..0x3C all return 0, err=0.
- Store word 0xDEADBEEF at 0x10, then lb at 0x13 -> 0xFFFFFFDE; lbu at 0x13 -> 0x000000DE; lh at 0x10 -> 0xFFFFBEEF; lhu at 0x12 -> 0x0000DEAD.
- sb 0x7F to 0x21 over word 0x00000000 -> lw 0x20 returns 0x00007F00. sh 0x1234 to 0x22 -> lw 0x20 returns 0x12347F00.
- Misaligned sh at 0x01, sw at 0x06, size=11, and out-of-range sw at 0x40 (DEPTH=16) -> each gives rsp_err=1, rdata=0. A subsequent lw of the target words shows them unchanged.
- Back-to-back: sw 0xA5A5A5A5 at 0x08, then lw 0x08 on the next cycle -> rsp_valid on consecutive cycles, and the load returns 0xA5A5A5A5.
- Reset pulsed during CLEAR at clr_idx=7, and again one cycle after a load accept -> CLEAR restarts (full DEPTH cycles), no rsp_valid is emitted, and all words read 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data/instruction memory blocks:
// access-size encodings, the controller state type and byte-enable decode.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Byte lanes touched by an access of the given size starting at lane.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load formatter: picks the addressed byte/half out of a
// 32-bit word, right-aligns it and sign- or zero-extends it.
module load_align_ext
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic        sign_b;
    logic        sign_h;

    assign shifted = word_i >> {lane_i, 3'b000};
    assign sign_b  = ~unsigned_i & shifted[7];
    assign sign_h  = ~unsigned_i & shifted[15];

    // Select and extend according to access size; words pass through.
    always_comb begin
        data_o = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{sign_b}}, shifted[7:0]};
            SZ_HALF: data_o = {{16{sign_h}}, shifted[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the MEM stage. A clear sequencer zeroes
// the array after reset; then byte/half/word loads and stores are served
// with a one-cycle registered response.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only in IDLE. Each accepted
// request yields exactly one rsp_valid pulse in the following cycle and the
// response side has no backpressure. rsp_rdata/rsp_err hold until the next
// response or reset.
module data_memory_ctrl
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output state_e            dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
    logic [31:0]       mem_q [DEPTH];

    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              accept;
    logic              acc_err;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       load_data;

    assign idx    = req_addr[IDX_W+1:2];
    assign lane   = req_addr[1:0];
    assign accept = req_valid && req_ready;

    // Out-of-range covers any address bit above the array's byte span.
    assign acc_err = (req_size == SZ_ILL)
                   || ((req_size == SZ_HALF) && lane[0])
                   || ((req_size == SZ_WORD) && (lane != 2'b00))
                   || (|req_addr[ADDR_W-1:IDX_W+2]);

    assign be = byte_en(req_size, lane);

    // Store data replicated across lanes so byte enables alone select it.
    assign wdata_rep = (req_size == SZ_BYTE) ? {4{req_wdata[7:0]}}
                     : (req_size == SZ_HALF) ? {2{req_wdata[15:0]}}
                     : req_wdata;

    load_align_ext u_align (
        .word_i     (mem_q[idx]),
        .lane_i     (lane),
        .size_i     (req_size),
        .unsigned_i (req_unsigned),
        .data_o     (load_data)
    );

    // Next-state: CLEAR walks every index once, then parks in IDLE.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and clear-index registers; reset restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Memory array: clear writes in CLEAR, byte-enabled stores in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_idx_q] <= '0;
            end else if (accept && req_we && !acc_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Registered response; loads read the array before this edge's write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_err_q   <= acc_err;
                rsp_rdata_q <= (acc_err || req_we) ? 32'h0 : load_data;
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CLEAR);
    assign dbg_state = state_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl with DEPTH=16: directed scenarios plus a
// randomized sequence checked against a byte-array reference model.
module tb_data_memory_ctrl;
  import mips_mem_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int NBYTES = DEPTH * 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  state_e      dbg_state;

  data_memory_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0] model_mem [NBYTES];

  function automatic void model_clear();
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd3) return 1'b1;
    if (addr >= 32'(NBYTES)) return 1'b1;
    if (sz == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] addr);
    int n = 1 << sz;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(model_mem[int'(addr) + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  function automatic void model_store(input logic [1:0] sz, input logic [31:0] addr,
                                      input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) model_mem[int'(addr) + i] = wd[8*i +: 8];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  // Present one request for one edge and sample the response after it.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic v, output logic [31:0] rd, output logic e);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    v = rsp_valid; rd = rsp_rdata; e = rsp_err;
    idle_inputs();
  endtask

  // Wait for req_ready with reset low; returns edges taken, -1 on timeout.
  // Also reports whether any rsp_valid appeared meanwhile.
  task automatic wait_ready(output int edges, output logic saw_rsp);
    edges = -1; saw_rsp = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_rsp = 1'b1;
      if (req_ready) begin edges = i; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic v, e; logic [31:0] rd;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs valid=%0b err=%0b rdata=%h ready=%0b want 0/0/0/0",
               rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL clear_cycle%0d busy=%0b ready=%0b want 1/0", i, busy, req_ready);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_done busy=%0b ready=%0b want 0/1", busy, req_ready);
    end
    model_clear();
    for (int a = 0; a < NBYTES; a += 4) begin
      issue(1'b0, SZ_WORD, 1'b0, 32'(a), 32'h0, v, rd, e);
      checks++;
      if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b0) begin
        errors++;
        $display("FAIL zero_load@%h v=%0b rd=%h e=%0b want 1/00000000/0", a, v, rd, e);
      end
    end
  endtask

  task automatic test_load_ext();
    logic v, e; logic [31:0] rd;
    logic [1:0]  sz   [4] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF};
    logic        uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad   [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] want [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, v, rd, e);
    model_store(SZ_WORD, 32'h10, 32'hDEADBEEF);
    checks++;
    if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL sw_rsp v=%0b rd=%h e=%0b want 1/00000000/0", v, rd, e);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], uns[i], ad[i], 32'h0, v, rd, e);
      checks++;
      if (v !== 1'b1 || rd !== want[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL load_ext%0d v=%0b rd=%h e=%0b want 1/%h/0", i, v, rd, e, want[i]);
      end
    end
  endtask

  task automatic test_sub_word_store();
    logic v, e; logic [31:0] rd;
    issue(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h0000007F, v, rd, e);
    model_store(SZ_BYTE, 32'h21, 32'h7F);
    issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, v, rd, e);
    checks++;
    if (v !== 1'b1 || rd !== 32'h00007F00 || e !== 1'b0) begin
      errors++;
      $display("FAIL sb_merge rd=%h want 00007f00", rd);
    end
    issue(1'b1, SZ_HALF, 1'b0, 32'h22, 32'hFFFF1234, v, rd, e);
    model_store(SZ_HALF, 32'h22, 32'h1234);
    issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, v, rd, e);
    checks++;
    if (v !== 1'b1 || rd !== 32'h12347F00 || e !== 1'b0) begin
      errors++;
      $display("FAIL sh_merge rd=%h want 12347f00", rd);
    end
  endtask

  task automatic test_errors();
    logic v, e; logic [31:0] rd;
    logic [1:0]  sz [4] = '{SZ_HALF, SZ_WORD, SZ_ILL, SZ_WORD};
    logic [31:0] ad [4] = '{32'h01, 32'h06, 32'h00, 32'h40};
    issue(1'b1, SZ_WORD, 1'b0, 32'h00, 32'h11223344, v, rd, e);
    issue(1'b1, SZ_WORD, 1'b0, 32'h04, 32'h55667788, v, rd, e);
    model_store(SZ_WORD, 32'h00, 32'h11223344);
    model_store(SZ_WORD, 32'h04, 32'h55667788);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, sz[i], 1'b0, ad[i], 32'hFFFFFFFF, v, rd, e);
      checks++;
      if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b1) begin
        errors++;
        $display("FAIL err_store%0d v=%0b rd=%h e=%0b want 1/00000000/1", i, v, rd, e);
      end
    end
    issue(1'b0, SZ_ILL, 1'b0, 32'h04, 32'h0, v, rd, e);
    checks++;
    if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b1) begin
      errors++;
      $display("FAIL err_load rd=%h e=%0b want 00000000/1", rd, e);
    end
    issue(1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, v, rd, e);
    checks++;
    if (rd !== 32'h11223344 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_word0_kept rd=%h want 11223344", rd);
    end
    issue(1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, v, rd, e);
    checks++;
    if (rd !== 32'h55667788 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_word1_kept rd=%h want 55667788", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic v1, e1, v2, e2; logic [31:0] rd1, rd2;
    issue(1'b1, SZ_WORD, 1'b0, 32'h08, 32'hA5A5A5A5, v1, rd1, e1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, v2, rd2, e2);
    model_store(SZ_WORD, 32'h08, 32'hA5A5A5A5);
    checks++;
    if (v1 !== 1'b1 || v2 !== 1'b1 || rd2 !== 32'hA5A5A5A5 || e2 !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back v=%0b%0b rd=%h want 11/a5a5a5a5", v1, v2, rd2);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rsp_hold valid=%0b rd=%h want 0/a5a5a5a5", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_random();
    logic v, e; logic [31:0] rd;
    logic we, uns, exp_e; logic [1:0] sz; logic [31:0] addr, wd, exp_rd;
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      addr = 32'($urandom_range(0, NBYTES + 15));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~((32'h1 << sz) - 32'h1);
      if ($urandom_range(0, 19) == 0) addr = addr | 32'h0001_0000;
      exp_e  = model_err(sz, addr);
      exp_rd = (exp_e || we) ? 32'h0 : model_load(sz, uns, addr);
      issue(we, sz, uns, addr, wd, v, rd, e);
      if (we && !exp_e) model_store(sz, addr, wd);
      checks++;
      if (v !== 1'b1 || rd !== exp_rd || e !== exp_e) begin
        errors++;
        $display("FAIL rand%0d we=%0b sz=%0d u=%0b a=%h v=%0b rd=%h e=%0b want 1/%h/%0b",
                 n, we, sz, uns, addr, v, rd, e, exp_rd, exp_e);
      end
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    for (int a = 0; a < NBYTES; a += 4) begin
      issue(1'b0, SZ_WORD, 1'b0, 32'(a), 32'h0, v, rd, e);
      exp_rd = model_load(SZ_WORD, 1'b0, 32'(a));
      checks++;
      if (rd !== exp_rd || e !== 1'b0) begin
        errors++;
        $display("FAIL rand_final@%h rd=%h want %h", a, rd, exp_rd);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic v, e; logic [31:0] rd;
    logic bad = 1'b0;
    for (int a = 0; a < NBYTES; a += 4) begin
      issue(1'b0, SZ_WORD, 1'b0, 32'(a), 32'h0, v, rd, e);
      if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_zero last rd=%h want all words 00000000", tag, rd);
    end
  endtask

  task automatic test_reset_restart();
    int edges; logic saw;
    // Reset during CLEAR at clr_idx=7.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    wait_ready(edges, saw);
    checks++;
    if (edges != DEPTH || saw) begin
      errors++;
      $display("FAIL restart_mid_clear edges=%0d rsp_seen=%0b want %0d/0", edges, saw, DEPTH);
    end
    check_all_zero("mid_clear");
    // Reset one cycle after a load accept.
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 32'h0;
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_after_load valid=%0b rd=%h busy=%0b want 0/00000000/1",
               rsp_valid, rsp_rdata, busy);
    end
    reset = 1'b0;
    wait_ready(edges, saw);
    checks++;
    if (edges != DEPTH || saw) begin
      errors++;
      $display("FAIL restart_after_load edges=%0d rsp_seen=%0b want %0d/0", edges, saw, DEPTH);
    end
    check_all_zero("after_load");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load_ext();
    test_sub_word_store();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
